// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed N-digit common-anode 7-segment driver with
// frame-locked shadow inputs, PWM brightness, dead time and frame-locked blinking.
module seven_seg_scanner #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 1024,
   parameter int BRIGHT_W     = 4,
   parameter int DEAD         = 4,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [7:0]              segment,
   output logic [NUM_DIGITS-1:0]   enable,
   output logic                    frame_done
);
   localparam int CW   = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int LW   = CW + 1;
   localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam int FW   = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam int STEP = SCAN_DIV >> BRIGHT_W;

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [FW-1:0]           frame_cnt;
   logic                    blink_phase;
   logic                    loaded;
   logic [4*NUM_DIGITS-1:0] digits_s;
   logic [NUM_DIGITS-1:0]   dp_s;
   logic [NUM_DIGITS-1:0]   blank_s;
   logic [NUM_DIGITS-1:0]   blink_s;
   logic [BRIGHT_W-1:0]     bright_s;
   logic                    slot_end;
   logic                    frame_wrap;
   logic                    active;
   logic                    dark;
   logic [LW-1:0]           lit_end;
   logic [3:0]              hex;
   logic [6:0]              seg_abc;

   function automatic logic [6:0] decode(input logic [3:0] h);
      case (h)
         4'h0: decode = 7'b0000001;
         4'h1: decode = 7'b1001111;
         4'h2: decode = 7'b0010010;
         4'h3: decode = 7'b0000110;
         4'h4: decode = 7'b1001100;
         4'h5: decode = 7'b0100100;
         4'h6: decode = 7'b0100000;
         4'h7: decode = 7'b0001111;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0000100;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b1100000;
         4'hC: decode = 7'b0110001;
         4'hD: decode = 7'b1000010;
         4'hE: decode = 7'b0110000;
         default: decode = 7'b0111000;
      endcase
   endfunction

   always_comb begin
      slot_end   = cnt == CW'(SCAN_DIV - 1);
      frame_wrap = loaded && slot_end && idx == IW'(NUM_DIGITS - 1);
      lit_end    = LW'((32'(bright_s) + 32'd1) * 32'(STEP));
      active     = int'(cnt) >= DEAD && {1'b0, cnt} < lit_end;
      hex        = digits_s[4*idx +: 4];
      seg_abc    = decode(hex);
      dark       = !loaded || !active || blank_s[idx] || (blink_s[idx] && blink_phase);
   end

   // The first edge after reset only loads the shadows; scanning starts on the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
         loaded      <= 1'b0;
         digits_s    <= '0;
         dp_s        <= '0;
         blank_s     <= '0;
         blink_s     <= '0;
         bright_s    <= '0;
         segment     <= 8'hFF;
         enable      <= '1;
         frame_done  <= 1'b0;
      end else begin
         loaded     <= 1'b1;
         frame_done <= frame_wrap;
         if (!loaded || frame_wrap) begin
            digits_s <= digits;
            dp_s     <= dp;
            blank_s  <= blank;
            blink_s  <= blink_mask;
            bright_s <= brightness;
         end
         if (loaded) begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
               idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
         end
         if (frame_wrap) begin
            frame_cnt <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
            if (frame_cnt == FW'(BLINK_FRAMES - 1))
               blink_phase <= ~blink_phase;
         end
         segment <= dark ? 8'hFF : {seg_abc, ~dp_s[idx]};
         enable  <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
      end
   end

   a_one_digit: assert property (@(posedge clk) disable iff (rst) $countones(~enable) <= 1);
endmodule
